// File: rtl/jk_excitation_driver_if.sv
// Target handshake plus JK bank excitation/feedback bundle for jk_excitation_driver.
// master = the driver block, slave = sequence source / flip-flop bank side.
interface jk_excitation_driver_if #(
    parameter int WIDTH = 4
);
    logic             tgt_valid;
    logic [WIDTH-1:0] tgt_data;
    logic             tgt_ready;
    logic [WIDTH-1:0] q_in;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             load;
    logic             done;
    logic             mismatch;
    logic [7:0]       err_cnt;

    modport master (
        input  tgt_valid, tgt_data, q_in,
        output tgt_ready, j, k, load, done, mismatch, err_cnt
    );

    modport slave (
        output tgt_valid, tgt_data, q_in,
        input  tgt_ready, j, k, load, done, mismatch, err_cnt
    );
endinterface

// File: rtl/jk_excitation_driver.sv
// Computes one-edge J/K excitation moving a JK bank from q_in to a target word,
// then checks the bank after a settle delay and tracks mismatches.
//
// state    | meaning
// S_IDLE   | bank held (j=k=0), ready for a target
// S_DRIVE  | load=1, j/k carry the excitation for one cycle
// S_SETTLE | bank held, settle counter runs down, check on terminal count
module jk_excitation_driver #(
    parameter int WIDTH         = 4,
    parameter int XFILL         = 0,
    parameter int SETTLE_CYCLES = 1
) (
    input logic                   i_clk,
    input logic                   i_rst,
    jk_excitation_driver_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SETTLE} state_t;

    localparam logic [WIDTH-1:0] XMASK     = (XFILL != 0) ? '1 : '0;
    localparam logic [3:0]       SETTLE_LD = 4'(SETTLE_CYCLES);

    state_t           r_state;
    logic [WIDTH-1:0] r_target;
    logic [WIDTH-1:0] r_j;
    logic [WIDTH-1:0] r_k;
    logic             r_load;
    logic             r_done;
    logic             r_mismatch;
    logic [7:0]       r_err_cnt;
    logic [3:0]       r_cnt;

    state_t           w_state_nx;
    logic [WIDTH-1:0] w_target_nx;
    logic [WIDTH-1:0] w_j_nx;
    logic [WIDTH-1:0] w_k_nx;
    logic             w_load_nx;
    logic             w_done_nx;
    logic             w_mismatch_nx;
    logic [7:0]       w_err_cnt_nx;
    logic [3:0]       w_cnt_nx;
    logic [WIDTH-1:0] w_exc_j;
    logic [WIDTH-1:0] w_exc_k;
    logic             w_diff;

    // Don't-care terms (hold-side of each transition) take the XFILL value.
    assign w_exc_j = (~bus.q_in & bus.tgt_data) | (bus.q_in & XMASK);
    assign w_exc_k = (bus.q_in & ~bus.tgt_data) | (~bus.q_in & XMASK);
    assign w_diff  = (bus.q_in != r_target);

    always_comb begin
        w_state_nx    = r_state;
        w_target_nx   = r_target;
        w_j_nx        = '0;
        w_k_nx        = '0;
        w_load_nx     = 1'b0;
        w_done_nx     = 1'b0;
        w_mismatch_nx = r_mismatch;
        w_err_cnt_nx  = r_err_cnt;
        w_cnt_nx      = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (bus.tgt_valid) begin
                    w_target_nx = bus.tgt_data;
                    w_j_nx      = w_exc_j;
                    w_k_nx      = w_exc_k;
                    w_load_nx   = 1'b1;
                    w_state_nx  = S_DRIVE;
                end
            end
            S_DRIVE: begin
                w_cnt_nx   = SETTLE_LD;
                w_state_nx = S_SETTLE;
            end
            S_SETTLE: begin
                w_cnt_nx = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_done_nx     = 1'b1;
                    w_mismatch_nx = w_diff;
                    if (w_diff && (r_err_cnt != 8'hFF)) begin
                        w_err_cnt_nx = r_err_cnt + 8'd1;
                    end
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_target   <= '0;
            r_j        <= '0;
            r_k        <= '0;
            r_load     <= 1'b0;
            r_done     <= 1'b0;
            r_mismatch <= 1'b0;
            r_err_cnt  <= 8'd0;
            r_cnt      <= 4'd0;
        end else begin
            r_state    <= w_state_nx;
            r_target   <= w_target_nx;
            r_j        <= w_j_nx;
            r_k        <= w_k_nx;
            r_load     <= w_load_nx;
            r_done     <= w_done_nx;
            r_mismatch <= w_mismatch_nx;
            r_err_cnt  <= w_err_cnt_nx;
            r_cnt      <= w_cnt_nx;
        end
    end

    assign bus.tgt_ready = (r_state == S_IDLE);
    assign bus.j         = r_j;
    assign bus.k         = r_k;
    assign bus.load      = r_load;
    assign bus.done      = r_done;
    assign bus.mismatch  = r_mismatch;
    assign bus.err_cnt   = r_err_cnt;
endmodule

// File: tb/tb_jk_excitation_driver.sv
// Directed bench: three driver instances (XFILL 0/1, SETTLE 1/3), each closing
// the loop through a behavioural JK flip-flop bank.
module tb_jk_excitation_driver;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1, rst2;
    logic pre_en;
    logic stuck0;
    logic [3:0] bank0, bank1, bank2;
    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt2 = 0;

    jk_excitation_driver_if #(.WIDTH(4)) if0 ();
    jk_excitation_driver_if #(.WIDTH(4)) if1 ();
    jk_excitation_driver_if #(.WIDTH(4)) if2 ();

    jk_excitation_driver #(.WIDTH(4), .XFILL(0), .SETTLE_CYCLES(1)) u0 (
        .i_clk(clk), .i_rst(rst0), .bus(if0));
    jk_excitation_driver #(.WIDTH(4), .XFILL(1), .SETTLE_CYCLES(1)) u1 (
        .i_clk(clk), .i_rst(rst1), .bus(if1));
    jk_excitation_driver #(.WIDTH(4), .XFILL(0), .SETTLE_CYCLES(3)) u2 (
        .i_clk(clk), .i_rst(rst2), .bus(if2));

    // JK bank: q+ = J&~q | ~K&q
    always @(posedge clk) begin
        if (pre_en) begin
            bank0 <= 4'b0000;
            bank1 <= 4'b1010;
            bank2 <= 4'b0000;
        end else begin
            bank0 <= (if0.j & ~bank0) | (~if0.k & bank0);
            bank1 <= (if1.j & ~bank1) | (~if1.k & bank1);
            bank2 <= (if2.j & ~bank2) | (~if2.k & bank2);
        end
    end

    assign if0.q_in = stuck0 ? 4'b0000 : bank0;
    assign if1.q_in = bank1;
    assign if2.q_in = bank2;

    always @(posedge clk) begin
        if (if2.done === 1'b1) done_cnt2 <= done_cnt2 + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int dc;
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        pre_en = 1'b1; stuck0 = 1'b0;
        if0.tgt_valid = 1'b0; if0.tgt_data = 4'b0000;
        if1.tgt_valid = 1'b0; if1.tgt_data = 4'b0000;
        if2.tgt_valid = 1'b0; if2.tgt_data = 4'b0000;
        tick();
        tick();
        pre_en = 1'b0;
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;

        check("rst_ready",    32'(if0.tgt_ready), 32'h1);
        check("rst_j",        32'(if0.j),         32'h0);
        check("rst_k",        32'(if0.k),         32'h0);
        check("rst_load",     32'(if0.load),      32'h0);
        check("rst_done",     32'(if0.done),      32'h0);
        check("rst_mismatch", 32'(if0.mismatch),  32'h0);
        check("rst_err_cnt",  32'(if0.err_cnt),   32'h0);

        // 0000 -> 1010, XFILL=0
        if0.tgt_valid = 1'b1; if0.tgt_data = 4'b1010;
        tick();
        if0.tgt_valid = 1'b0; if0.tgt_data = 4'b0000;
        check("t1_load",  32'(if0.load),      32'h1);
        check("t1_j",     32'(if0.j),         32'b1010);
        check("t1_k",     32'(if0.k),         32'b0000);
        check("t1_ready", 32'(if0.tgt_ready), 32'h0);
        tick();
        check("t1_load_off", 32'(if0.load), 32'h0);
        check("t1_j_off",    32'(if0.j),    32'h0);
        check("t1_k_off",    32'(if0.k),    32'h0);
        check("t1_done_early", 32'(if0.done), 32'h0);
        tick();
        check("t1_done",     32'(if0.done),      32'h1);
        check("t1_mismatch", 32'(if0.mismatch),  32'h0);
        check("t1_err",      32'(if0.err_cnt),   32'h0);
        check("t1_ready_dn", 32'(if0.tgt_ready), 32'h1);
        check("t1_bank",     32'(bank0),         32'b1010);
        tick();
        check("t1_done_pulse", 32'(if0.done), 32'h0);

        // 1010 -> 0110, XFILL=0
        if0.tgt_valid = 1'b1; if0.tgt_data = 4'b0110;
        tick();
        if0.tgt_valid = 1'b0;
        check("t2_j", 32'(if0.j), 32'b0100);
        check("t2_k", 32'(if0.k), 32'b1000);
        tick(); tick();
        check("t2_done",     32'(if0.done),     32'h1);
        check("t2_mismatch", 32'(if0.mismatch), 32'h0);
        check("t2_bank",     32'(bank0),        32'b0110);
        tick();

        // target equal to q: XFILL=0 gives j=k=0 with load still asserted
        if0.tgt_valid = 1'b1; if0.tgt_data = 4'b0110;
        tick();
        if0.tgt_valid = 1'b0;
        check("teq_load", 32'(if0.load), 32'h1);
        check("teq_j",    32'(if0.j),    32'h0);
        check("teq_k",    32'(if0.k),    32'h0);
        tick(); tick();
        check("teq_done", 32'(if0.done),     32'h1);
        check("teq_mm",   32'(if0.mismatch), 32'h0);
        tick();

        // 1010 -> 0110, XFILL=1 (toggle style)
        if1.tgt_valid = 1'b1; if1.tgt_data = 4'b0110;
        tick();
        if1.tgt_valid = 1'b0;
        check("t3_j", 32'(if1.j), 32'b1110);
        check("t3_k", 32'(if1.k), 32'b1101);
        tick(); tick();
        check("t3_done",     32'(if1.done),     32'h1);
        check("t3_mismatch", 32'(if1.mismatch), 32'h0);
        check("t3_bank",     32'(bank1),        32'b0110);
        tick();

        // stuck q_in, target 1111: mismatch and saturating error count
        stuck0 = 1'b1;
        if0.tgt_valid = 1'b1; if0.tgt_data = 4'b1111;
        tick(); tick(); tick();
        check("t4_done",     32'(if0.done),     32'h1);
        check("t4_mismatch", 32'(if0.mismatch), 32'h1);
        check("t4_err1",     32'(if0.err_cnt),  32'h1);
        for (int n = 2; n <= 300; n++) begin
            tick(); tick(); tick();
            if (n == 255) check("t4_err255", 32'(if0.err_cnt), 32'd255);
        end
        check("t4_done300", 32'(if0.done),    32'h1);
        check("t4_err_sat", 32'(if0.err_cnt), 32'd255);
        if0.tgt_valid = 1'b0;
        tick();
        check("t4_no_accept", 32'(if0.tgt_ready), 32'h1);
        check("t4_mm_held",   32'(if0.mismatch),  32'h1);
        check("t4_done_low",  32'(if0.done),      32'h0);
        stuck0 = 1'b0;
        if0.tgt_valid = 1'b1; if0.tgt_data = 4'b0000;
        tick();
        if0.tgt_valid = 1'b0;
        check("t4b_k", 32'(if0.k), 32'b1111);
        tick(); tick();
        check("t4b_done",   32'(if0.done),     32'h1);
        check("t4b_mm_clr", 32'(if0.mismatch), 32'h0);
        check("t4b_err",    32'(if0.err_cnt),  32'd255);
        tick();

        // SETTLE_CYCLES=3, valid held high: accepts 5 cycles apart
        dc = done_cnt2;
        if2.tgt_valid = 1'b1; if2.tgt_data = 4'b0001;
        tick();
        check("t5a_load", 32'(if2.load), 32'h1);
        check("t5a_j",    32'(if2.j),    32'b0001);
        if2.tgt_data = 4'b0011;
        tick();
        check("t5a_jk_off", 32'({if2.j, if2.k}), 32'h0);
        tick(); tick();
        check("t5a_settle_jk",    32'({if2.j, if2.k}), 32'h0);
        check("t5a_settle_ready", 32'(if2.tgt_ready),   32'h0);
        check("t5a_settle_done",  32'(if2.done),        32'h0);
        tick();
        check("t5a_done",  32'(if2.done),      32'h1);
        check("t5a_ready", 32'(if2.tgt_ready), 32'h1);
        check("t5a_jk",    32'({if2.j, if2.k}), 32'h0);
        tick();
        check("t5b_load", 32'(if2.load), 32'h1);
        check("t5b_j",    32'(if2.j),    32'b0010);
        check("t5b_k",    32'(if2.k),    32'b0000);
        if2.tgt_data = 4'b0111;
        tick(); tick(); tick(); tick();
        check("t5b_done", 32'(if2.done), 32'h1);
        tick();
        check("t5c_j", 32'(if2.j), 32'b0100);
        if2.tgt_valid = 1'b0;
        tick(); tick(); tick(); tick();
        check("t5c_done",  32'(if2.done),     32'h1);
        check("t5c_mm",    32'(if2.mismatch), 32'h0);
        check("t5c_bank",  32'(bank2),        32'b0111);
        tick();
        check("t5_done_count", 32'(done_cnt2 - dc), 32'd3);

        // reset in SETTLE
        dc = done_cnt2;
        if2.tgt_valid = 1'b1; if2.tgt_data = 4'b1000;
        tick();
        if2.tgt_valid = 1'b0;
        tick(); tick();
        rst2 = 1'b1;
        tick();
        rst2 = 1'b0;
        check("t6_ready", 32'(if2.tgt_ready),   32'h1);
        check("t6_done",  32'(if2.done),        32'h0);
        check("t6_jk",    32'({if2.j, if2.k}),  32'h0);
        check("t6_err",   32'(if2.err_cnt),     32'h0);
        tick(); tick(); tick(); tick();
        check("t6_no_done", 32'(done_cnt2 - dc), 32'd0);

        // reset coincident with a handshake: word not accepted
        rst2 = 1'b1; if2.tgt_valid = 1'b1; if2.tgt_data = 4'b0101;
        tick();
        rst2 = 1'b0; if2.tgt_valid = 1'b0;
        check("t7_load",  32'(if2.load),      32'h0);
        check("t7_ready", 32'(if2.tgt_ready), 32'h1);
        tick();
        check("t7_still_idle", 32'(if2.load), 32'h0);
        check("t7_ready2",     32'(if2.tgt_ready), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/jk_excitation_driver.md
Name: jk_excitation_driver

Overview:
- Drives a bank of WIDTH JK flip-flops toward a requested next-state word.
- Works in the opposite direction to the flip-flop. It takes the current state (q feedback) and a target state, and produces the J/K excitation that moves each bit from q to target in exactly one clock edge.
- After that edge it checks the feedback and reports match or mismatch.
- Sits between a sequence source (valid/ready) and the flip-flop bank.

Parameters:
- WIDTH, 4, number of JK flip-flops driven.
- XFILL, 0, value substituted for don't-care excitation terms. 0 gives set/reset/hold style; 1 gives toggle style.
- SETTLE_CYCLES, 1, cycles to wait after the drive cycle before sampling q_in. Legal range 1..15.

Ports:
- clk, input, 1, single clock; all state updates on its rising edge.
- rst, input, 1, synchronous reset, active-high.
- tgt_valid, input, 1, target word available.
- tgt_data, input, WIDTH, requested next state of the flip-flop bank.
- tgt_ready, output, 1, block can accept a target.
- q_in, input, WIDTH, q outputs of the flip-flop bank.
- j, output, WIDTH, J inputs to the bank.
- k, output, WIDTH, K inputs to the bank.
- load, output, 1, high during the single cycle in which j/k carry a real excitation.
- done, output, 1, one-cycle pulse when a transfer has been checked.
- mismatch, output, 1, result of the last check (1 = q_in differed from target). Held until the next done.
- err_cnt, output, 8, count of mismatched transfers; saturates at 255.

Behaviour:
- Reset: registered on a rising edge of clk with rst=1. Same behaviour whenever asserted, including mid-transfer.
  - state=IDLE, j=0, k=0, load=0, done=0, mismatch=0, err_cnt=0, settle counter=0.
  - Any captured target is discarded.
- States: IDLE, DRIVE, SETTLE.
- IDLE:
  - tgt_ready=1; j=k=0, which holds the bank.
  - Transfer accepted on an edge with tgt_valid=1 and tgt_ready=1 (call it E0).
  - At E0: register target=tgt_data, compute j/k from q_in sampled at E0, go to DRIVE.
- Excitation rule, per bit i, with q=q_in[i] and t=target[i]:
  - q=0, t=0: j=0, k=XFILL
  - q=0, t=1: j=1, k=XFILL
  - q=1, t=0: j=XFILL, k=1
  - q=1, t=1: j=XFILL, k=0
- DRIVE:
  - Lasts exactly one cycle (E0 to E1): load=1, j/k hold the computed excitation, tgt_ready=0.
  - At E1: j=k=0, load=0, settle counter loaded with SETTLE_CYCLES, go to SETTLE.
- SETTLE:
  - tgt_ready=0, j=k=0.
  - Counter decrements on each edge.
  - On the edge where the counter reaches 0: register mismatch=(q_in!=target), pulse done=1 for one cycle, and if mismatch increment err_cnt unless it is 255. Go to IDLE.
- Latency: done is high in the cycle that starts SETTLE_CYCLES+1 edges after E0.
- Back-to-back operation:
  - tgt_ready is 1 in the same cycle as done, so a new target may be accepted on the edge that ends the done cycle.
  - Throughput: one word per SETTLE_CYCLES+2 cycles.
- tgt_valid while tgt_ready=0: ignored. tgt_data need not be held once accepted.
- q_in changes during DRIVE/SETTLE do not alter j/k; only the final sample is compared.
- Target equal to current q is legal. The excitation still follows the rule; with XFILL=0 it yields j=k=0.
- rst coincident with a tgt_valid handshake: reset wins, and the word is not accepted.

Test Plan:
- WIDTH=4, XFILL=0, q_in=0000, tgt_data=1010 -> j=1010, k=0000, load=1 for one cycle. With a model bank, done at E0+2 edges, mismatch=0, err_cnt=0.
- XFILL=0, q_in=1010, tgt_data=0110 -> j=0100, k=1000. Bank ends at 0110, mismatch=0.
- XFILL=1, q_in=1010, tgt_data=0110 -> j=1110, k=1101. Bank (toggle on bits 3,2) ends at 0110, mismatch=0.
- Bench forces q_in stuck at 0000, tgt_data=1111 -> done with mismatch=1, err_cnt=1. Repeat 300 transfers -> err_cnt saturates at 255.
- SETTLE_CYCLES=3, tgt_valid held high with a sequence 0001, 0011, 0111 -> accepts spaced 5 cycles apart, three done pulses, j=k=0 outside DRIVE.
- rst asserted during SETTLE -> next cycle IDLE, tgt_ready=1, no done pulse, err_cnt=0, j=k=0.
